// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - MD handshake opcodes, debug state codes and default latencies
package md_pkg;

  localparam logic [2:0] MDOP_MULT  = 3'b000;
  localparam logic [2:0] MDOP_MULTU = 3'b001;
  localparam logic [2:0] MDOP_DIV   = 3'b010;
  localparam logic [2:0] MDOP_DIVU  = 3'b011;
  localparam logic [2:0] MDOP_MTHI  = 3'b100;
  localparam logic [2:0] MDOP_MTLO  = 3'b101;
  localparam logic [2:0] MDOP_IDLE  = 3'b110;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    MD_ST_IDLE     = 2'b00,
    MD_ST_MUL_WAIT = 2'b01,
    MD_ST_DIV_WAIT = 2'b10
  } md_state_e;

  // Ops 000..011 start a timed operation; 100/101 are immediate HI/LO writes.
  function automatic logic is_start_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/md_shadow_cnt.sv
// rtl/md_shadow_cnt.sv - shadow Busy countdown and sticky Busy-mismatch flag
module md_shadow_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_exp_busy,
  input  logic          i_md_busy,
  output logic          o_last,
  output logic          o_proto_err
);

  logic [CW-1:0] r_cnt;
  logic          r_proto_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (i_load) begin
        r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
      r_proto_err <= r_proto_err | (i_md_busy ^ i_exp_busy);
    end
  end

  assign o_last      = (r_cnt == CW'(1));
  assign o_proto_err = r_proto_err;

endmodule

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - E-stage initiator for the MD unit Start/MDOp/Busy handshake
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_md_cls,
  input  logic        e_md_vld,
  input  logic [2:0]  e_md_op,
  input  logic [31:0] e_srca,
  input  logic [31:0] e_srcb,
  input  logic        e_cancel,
  input  logic        md_busy,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic [31:0] md_srca,
  output logic [31:0] md_srcb,
  output logic        stall_d,
  output logic [1:0]  md_state,
  output logic        proto_err
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  md_state_e     r_state;
  md_state_e     w_state_nxt;
  logic          w_iss;
  logic          w_exp_busy;
  logic          w_last;
  logic          w_load;
  logic [CW-1:0] w_load_val;

  // Gating by IDLE keeps an mthi/mtlo away from a busy unit even if stall_d were bypassed.
  assign w_iss      = e_md_vld & ~e_cancel & (r_state == MD_ST_IDLE);
  assign w_exp_busy = (r_state != MD_ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MD_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    md_start    = 1'b0;
    md_op       = MDOP_IDLE;
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = '0;
    case (r_state)
      MD_ST_IDLE: begin
        if (w_iss) begin
          if (is_start_op(e_md_op)) begin
            md_start = 1'b1;
            md_op    = e_md_op;
            w_load   = 1'b1;
            if (e_md_op[1]) begin
              w_state_nxt = MD_ST_DIV_WAIT;
              w_load_val  = CW'(DIV_CYCLES);
            end else begin
              w_state_nxt = MD_ST_MUL_WAIT;
              w_load_val  = CW'(MULT_CYCLES);
            end
          end else if ((e_md_op == MDOP_MTHI) || (e_md_op == MDOP_MTLO)) begin
            md_op = e_md_op;
          end
        end
      end
      MD_ST_MUL_WAIT, MD_ST_DIV_WAIT: begin
        if (w_last) begin
          w_state_nxt = MD_ST_IDLE;
        end
      end
      default: w_state_nxt = MD_ST_IDLE;
    endcase
  end

  md_shadow_cnt #(
    .CW(CW)
  ) u_shadow_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_exp_busy (w_exp_busy),
    .i_md_busy  (md_busy),
    .o_last     (w_last),
    .o_proto_err(proto_err)
  );

  // Start-cycle term covers the edge before the unit raises Busy.
  assign stall_d  = d_md_cls & (md_start | w_exp_busy | md_busy);
  assign md_srca  = e_srca;
  assign md_srcb  = e_srcb;
  assign md_state = r_state;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - directed bench for md_issue_ctrl driving a behavioural MD unit
module tb_md_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_md_cls;
  logic        e_md_vld;
  logic [2:0]  e_md_op;
  logic [31:0] e_srca;
  logic [31:0] e_srcb;
  logic        e_cancel;
  logic        md_busy_dut;
  logic        force_low;
  logic        md_start;
  logic [2:0]  md_op;
  logic [31:0] md_srca;
  logic [31:0] md_srcb;
  logic        stall_d;
  logic [1:0]  md_state;
  logic        proto_err;

  logic [5:0]  u_cnt;
  logic [63:0] u_pend;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  int n_stall, n_start, n_state;

  always #5 clk = ~clk;

  md_issue_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .d_md_cls (d_md_cls),
    .e_md_vld (e_md_vld),
    .e_md_op  (e_md_op),
    .e_srca   (e_srca),
    .e_srcb   (e_srcb),
    .e_cancel (e_cancel),
    .md_busy  (md_busy_dut),
    .md_start (md_start),
    .md_op    (md_op),
    .md_srca  (md_srca),
    .md_srcb  (md_srcb),
    .stall_d  (stall_d),
    .md_state (md_state),
    .proto_err(proto_err)
  );

  // Behavioural MD unit: Busy for 5/10 cycles after Start, HI/LO written as Busy falls.
  assign md_busy_dut = (u_cnt != 6'd0) & ~force_low;

  always @(posedge clk) begin
    if (reset) begin
      u_cnt  <= 6'd0;
      u_pend <= 64'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else if (md_start) begin
      u_cnt <= md_op[1] ? 6'd10 : 6'd5;
      case (md_op[1:0])
        2'b00:   u_pend <= $signed({{32{md_srca[31]}}, md_srca}) * $signed({{32{md_srcb[31]}}, md_srcb});
        2'b01:   u_pend <= {32'd0, md_srca} * {32'd0, md_srcb};
        2'b10:   u_pend <= {32'($signed(md_srca) % $signed(md_srcb)), 32'($signed(md_srca) / $signed(md_srcb))};
        default: u_pend <= {md_srca % md_srcb, md_srca / md_srcb};
      endcase
    end else if (u_cnt != 6'd0) begin
      u_cnt <= u_cnt - 6'd1;
      if (u_cnt == 6'd1) {hi, lo} <= u_pend;
    end else if (md_op == 3'b100) begin
      hi <= md_srca;
    end else if (md_op == 3'b101) begin
      lo <= md_srca;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs from the current (already settled) cycle until stall_d drops, bounded to 40 cycles.
  task automatic wait_release(input logic [1:0] st, output int stalls, output int starts,
                              output int st_cycles);
    stalls = 0;
    starts = 0;
    st_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (!stall_d) break;
      stalls++;
      if (md_start) starts++;
      if (md_state == st) st_cycles++;
      tick();
      e_md_vld = 1'b0;
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; d_md_cls = 1'b0; e_md_vld = 1'b0; e_md_op = 3'b000;
    e_srca = 32'd0; e_srcb = 32'd0; e_cancel = 1'b0; force_low = 1'b0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_start", md_start, 0);
    chk("rst_op", md_op, 3'b110);
    chk("rst_stall", stall_d, 0);
    chk("rst_state", md_state, 0);
    chk("rst_perr", proto_err, 0);
    d_md_cls = 1'b1; e_md_vld = 1'b1; e_md_op = 3'b110;
    #1;
    chk("idle_cls_stall", stall_d, 0);
    chk("op110_op", md_op, 3'b110);
    chk("op110_start", md_start, 0);
    tick();
    chk("op110_state", md_state, 0);

    // 1) mult 7 x -3, mfhi in D
    e_md_op = 3'b000; e_srca = 32'd7; e_srcb = 32'hFFFFFFFD;
    #1;
    chk("t1_start", md_start, 1);
    chk("t1_op", md_op, 3'b000);
    chk("t1_srca", md_srca, 32'd7);
    chk("t1_srcb", md_srcb, 32'hFFFFFFFD);
    wait_release(2'b01, n_stall, n_start, n_state);
    chk("t1_stalls", n_stall, 6);
    chk("t1_starts", n_start, 1);
    chk("t1_mulwait", n_state, 5);
    chk("t1_hi", hi, 32'hFFFFFFFF);
    chk("t1_lo", lo, 32'hFFFFFFEB);
    chk("t1_perr", proto_err, 0);

    // 2) divu 100/7, mflo in D, issued back-to-back on the first idle cycle
    e_md_vld = 1'b1; e_md_op = 3'b011; e_srca = 32'd100; e_srcb = 32'd7;
    #1;
    chk("t2_start", md_start, 1);
    wait_release(2'b10, n_stall, n_start, n_state);
    chk("t2_stalls", n_stall, 11);
    chk("t2_divwait", n_state, 10);
    chk("t2_lo", lo, 32'd14);
    chk("t2_hi", hi, 32'd2);
    chk("t2_perr", proto_err, 0);

    // 3) mthi held in D while divu 50/8 runs; stray mthi in E is gated
    e_md_vld = 1'b1; e_md_op = 3'b011; e_srca = 32'd50; e_srcb = 32'd8;
    #1;
    chk("t3_start", md_start, 1);
    tick();
    e_md_vld = 1'b1; e_md_op = 3'b100; e_srca = 32'h1234;
    #1;
    chk("t3_gate_op", md_op, 3'b110);
    chk("t3_gate_start", md_start, 0);
    chk("t3_gate_stall", stall_d, 1);
    e_md_vld = 1'b0;
    #1;
    wait_release(2'b10, n_stall, n_start, n_state);
    chk("t3_stalls", n_stall, 10);
    chk("t3_divwait", n_state, 10);
    chk("t3_div_hi", hi, 32'd2);
    chk("t3_div_lo", lo, 32'd6);
    d_md_cls = 1'b0; e_md_vld = 1'b1; e_md_op = 3'b100; e_srca = 32'h1234;
    #1;
    chk("t3_mthi_op", md_op, 3'b100);
    chk("t3_mthi_start", md_start, 0);
    tick();
    e_md_vld = 1'b0;
    #1;
    chk("t3_hi", hi, 32'h1234);
    chk("t3_lo", lo, 32'd6);
    chk("t3_state", md_state, 0);

    // 4) cancelled div
    e_md_vld = 1'b1; e_md_op = 3'b010; e_srca = 32'd9; e_srcb = 32'd3; e_cancel = 1'b1;
    #1;
    chk("t4_start", md_start, 0);
    chk("t4_op", md_op, 3'b110);
    tick();
    e_md_vld = 1'b0; e_cancel = 1'b0; d_md_cls = 1'b1;
    #1;
    chk("t4_state", md_state, 0);
    chk("t4_stall", stall_d, 0);
    chk("t4_hi", hi, 32'h1234);
    chk("t4_lo", lo, 32'd6);

    // 5) reset during cycle 3 of a mult
    e_md_vld = 1'b1; e_md_op = 3'b000; e_srca = 32'd3; e_srcb = 32'd4;
    #1;
    tick();
    e_md_vld = 1'b0;
    tick(); tick();
    chk("t5_midstate", md_state, 2'b01);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t5_state", md_state, 0);
    chk("t5_stall", stall_d, 0);
    chk("t5_perr", proto_err, 0);

    // 6) Busy dropped for one cycle inside MUL_WAIT
    d_md_cls = 1'b0; e_md_vld = 1'b1; e_md_op = 3'b001; e_srca = 32'd2; e_srcb = 32'd3;
    #1;
    tick();
    e_md_vld = 1'b0;
    #1;
    chk("t6_state", md_state, 2'b01);
    tick();
    force_low = 1'b1;
    #1;
    chk("t6_perr_pre", proto_err, 0);
    tick();
    force_low = 1'b0;
    #1;
    chk("t6_perr_set", proto_err, 1);
    for (int k = 0; k < 8; k++) tick();
    chk("t6_perr_sticky", proto_err, 1);
    chk("t6_idle", md_state, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_perr_clr", proto_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
